fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 15: MSB index of one instruction word; words are WIDTH+1 bits.
REQ-002 SHALL have parameter DEPTH, default 1023: highest valid ROM address.
REQ-003 SHALL use address width $clog2(DEPTH)+1 bits (AW below) for every address port.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rom_addr, output, AW: read address to the downstream-registered ROM.
REQ-007 SHALL have port rom_data, input, WIDTH+1: ROM word, valid one cycle after rom_addr is sampled.
REQ-008 SHALL have port halt, input, 1: while high, no new fetch issues.
REQ-009 SHALL have ports jump_valid (input, 1) and jump_addr (input, AW): redirect the PC.
REQ-010 SHALL have ports instr (output, WIDTH+1), instr_pc (output, AW), instr_valid (output, 1): the fetched word and its address.
REQ-011 SHALL have port instr_ready, input, 1: consumer accepts when instr_valid && instr_ready.
REQ-012 SHALL have port done, output, 1: high in DONE state.

Function
REQ-013 SHALL keep a PC register; rom_addr is driven combinationally from PC.
REQ-014 SHALL implement FSM states RUN and DONE; RUN->DONE when address DEPTH is issued; DONE->RUN on jump_valid; no PC wrap-around.
REQ-015 SHALL issue a fetch in a cycle iff state==RUN, !halt, !jump_valid, and (buffered + inflight - pop) <= 1; on issue PC <= PC+1 and inflight <= 1, otherwise inflight <= 0.
REQ-016 SHALL capture rom_data with its address into a 2-entry FIFO on the edge after an issue edge; latency from issue edge to instr_valid high = 2 edges.
REQ-017 SHALL present the FIFO head on instr/instr_pc with instr_valid = FIFO non-empty; pop on valid&&ready.
REQ-018 SHALL hold instr and instr_pc stable while instr_valid && !instr_ready.
REQ-019 SHALL sustain one instruction per cycle when instr_ready stays high and halt is low.
REQ-020 SHALL, on jump_valid, flush FIFO, drop any in-flight word, set PC <= jump_addr, state <= RUN; the first fetch from jump_addr issues the next cycle.
REQ-021 SHALL treat jump_valid with a same-cycle handshake as: handshake completes, then flush; a word in flight at the jump is never presented.
REQ-022 SHALL ignore jump_addr > DEPTH by setting state DONE with PC unchanged and FIFO flushed.
REQ-023 SHALL keep FIFO contents and valid output during halt; only issue is blocked.

Reset
REQ-024 SHALL on rst_n low asynchronously set PC=0, state=RUN, inflight=0, FIFO empty, instr_valid=0, instr=0, instr_pc=0, done=0.
REQ-025 SHALL issue address 0 on the first rising edge after rst_n deasserts, absent halt or jump.
REQ-026 SHALL abort all in-flight work when reset asserts mid-operation; no stale word after release.

Structure
REQ-027 SHALL place the FSM state enum, AW derivation and FIFO depth constant (2) in shared package fetch_pkg.
REQ-028 SHALL instantiate one sub-module fetch_skid_fifo (2-entry, data+address, push/pop/flush, full/empty).

Verification
REQ-029 Reset release, ROM holds word k = k+0x100, ready=1 -> instr_valid high after 2nd edge; instr_pc 0,1,2,... with instr 0x100,0x101,... each cycle.
REQ-030 ready low for 5 cycles from instr_pc=3 -> instr stays 0x103, at most 2 buffered, no loss or duplication; stream resumes 3,4,5 on release.
REQ-031 jump_valid, jump_addr=40, while fetching 7 -> 7 and 8 never presented after jump edge; next instr_pc=40, instr 0x128.
REQ-032 DEPTH=15 run to end -> last instr_pc=15, done=1, rom_addr frozen; jump_addr=2 -> done=0, stream restarts at 2.
REQ-033 halt high 3 cycles mid-stream -> no issue, buffered words drain; sequence continues without gaps in instr_pc.
REQ-034 rst_n pulsed low with 2 buffered words -> instr_valid=0 immediately; after release stream restarts at instr_pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its skid FIFO.
package fetch_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW    = FIFO_PW + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } fetch_state_e;

  // Address width needed to reach the highest ROM address.
  function automatic int fetch_aw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO holding fetched words with their addresses; flush wins over push/pop.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [AW-1:0] push_addr,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] head_addr,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0]      data_q [FIFO_DEPTH];
  logic [DW-1:0]      data_d [FIFO_DEPTH];
  logic [AW-1:0]      addr_q [FIFO_DEPTH];
  logic [AW-1:0]      addr_d [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CW-1:0] count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FIFO_CW'(FIFO_DEPTH));
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = data_q[rd_ptr_q];
  assign head_addr = addr_q[rd_ptr_q];

  always_comb begin
    data_d   = data_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        data_d[wr_ptr_q] = push_data;
        addr_d[wr_ptr_q] = push_addr;
        wr_ptr_d         = wr_ptr_q + FIFO_PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + FIFO_PW'(1);
      end
      count_d = count_q + FIFO_CW'(do_push) - FIFO_CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      data_q   <= data_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks a registered ROM from address 0, buffers words in a
// 2-entry skid FIFO, and supports halt, jump redirect and end-of-ROM stop.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int WIDTH = 15,
  parameter  int DEPTH = 1023,
  localparam int AW    = fetch_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  input  logic [WIDTH:0] rom_data,
  input  logic          halt,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_addr,
  output logic [WIDTH:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] ipc_q, ipc_d;
  logic          inflight_q, inflight_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          issue;
  logic [1:0]    buffered;
  logic [2:0]    occupancy;

  // Handshake: a word transfers on every rising edge where instr_valid && instr_ready;
  // instr/instr_pc hold while valid is high and ready is low; a jump flushes after
  // any same-cycle transfer has completed.
  assign pop         = instr_valid && instr_ready;
  assign instr_valid = !fifo_empty;
  assign rom_addr    = pc_q;
  assign done        = (state_q == ST_DONE);

  // Words that will still occupy the FIFO once this cycle's pop and in-flight push land.
  assign buffered  = fifo_full ? 2'd2 : {1'b0, !fifo_empty};
  assign occupancy = {1'b0, buffered} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_RUN) && !halt && !jump_valid && (occupancy <= 3'd1);
  assign push      = inflight_q && !jump_valid;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = issue;
    ipc_d      = issue ? pc_q : ipc_q;
    if (jump_valid) begin
      if (jump_addr <= LAST_ADDR) begin
        pc_d    = jump_addr;
        state_d = ST_RUN;
      end else begin
        state_d = ST_DONE;
      end
    end else if (issue) begin
      // The last address freezes the PC rather than stepping past the ROM.
      if (pc_q == LAST_ADDR) begin
        state_d = ST_DONE;
      end else begin
        pc_d = pc_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_skid_fifo #(
    .DW(WIDTH + 1),
    .AW(AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rom_data),
    .push_addr (ipc_q),
    .pop       (pop),
    .flush     (jump_valid),
    .head_data (instr),
    .head_addr (instr_pc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a default-size instance and a DEPTH=15 instance share stimulus
// and are checked every cycle against a queue-level model of the fetch stream.
module tb_fetch_unit;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt  = 1'b0;
  logic        jv    = 1'b0;
  logic        ready = 1'b0;
  logic [10:0] ja    = '0;

  logic [10:0] ra0, ipc0;
  logic [15:0] rd0, ins0;
  logic        v0, dn0;
  logic [4:0]  ra1, ipc1;
  logic [15:0] rd1, ins1;
  logic        v1, dn1;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- clock / ROMs ----------------
  always #5 clk = ~clk;

  always @(posedge clk) rd0 <= {5'b0, ra0} + 16'h0100;
  always @(posedge clk) rd1 <= {11'b0, ra1} + 16'h0100;

  fetch_unit u_big (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (ra0),
    .rom_data    (rd0),
    .halt        (halt),
    .jump_valid  (jv),
    .jump_addr   (ja),
    .instr       (ins0),
    .instr_pc    (ipc0),
    .instr_valid (v0),
    .instr_ready (ready),
    .done        (dn0)
  );

  fetch_unit #(.WIDTH(15), .DEPTH(15)) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (ra1),
    .rom_data    (rd1),
    .halt        (halt),
    .jump_valid  (jv),
    .jump_addr   (ja[4:0]),
    .instr       (ins1),
    .instr_pc    (ipc1),
    .instr_valid (v1),
    .instr_ready (ready),
    .done        (dn1)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: next address to fetch, a word in flight, and the words buffered
  // for the consumer (oldest first).
  int m_pc [2];
  int m_ipc [2];
  int m_cnt [2];
  int m_buf [2][2];
  bit m_done [2];
  bit m_infl [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 1023 : 15;
  endfunction

  task automatic model_step(input int i);
    bit valid, pop, issue;
    int occ, ja_i;
    ja_i  = (i == 0) ? int'(ja) : int'(ja[4:0]);
    valid = (m_cnt[i] > 0);
    pop   = valid && ready;
    occ   = m_cnt[i] + int'(m_infl[i]) - int'(pop);
    issue = !m_done[i] && !halt && !jv && (occ <= 1);
    if (pop) begin
      m_buf[i][0] = m_buf[i][1];
      m_cnt[i]--;
    end
    if (jv) begin
      m_cnt[i] = 0;
    end else if (m_infl[i]) begin
      if (m_cnt[i] >= 2) begin
        vectors++;
        miscompares++;
        $display("FAIL model_overflow u%0d: got 3 buffered, expected at most 2", i);
      end else begin
        m_buf[i][m_cnt[i]] = m_ipc[i];
        m_cnt[i]++;
      end
    end
    m_infl[i] = issue;
    if (issue) m_ipc[i] = m_pc[i];
    if (jv) begin
      if (ja_i <= depth_of(i)) begin
        m_pc[i]   = ja_i;
        m_done[i] = 1'b0;
      end else begin
        m_done[i] = 1'b1;
      end
    end else if (issue) begin
      if (m_pc[i] == depth_of(i)) m_done[i] = 1'b1;
      else m_pc[i]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pc[i] = 0; m_ipc[i] = 0; m_cnt[i] = 0;
        m_done[i] = 1'b0; m_infl[i] = 1'b0;
        m_buf[i][0] = 0; m_buf[i][1] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  task automatic cmp(input int i, input logic v, input logic d, input logic [31:0] ra,
                     input logic [31:0] ins, input logic [31:0] pc);
    check($sformatf("u%0d.instr_valid", i), {31'b0, v}, {31'b0, m_cnt[i] > 0});
    check($sformatf("u%0d.done", i), {31'b0, d}, {31'b0, m_done[i]});
    check($sformatf("u%0d.rom_addr", i), ra, m_pc[i]);
    if (m_cnt[i] > 0) begin
      check($sformatf("u%0d.instr_pc", i), pc, m_buf[i][0]);
      check($sformatf("u%0d.instr", i), ins, (m_buf[i][0] + 32'h100) & 32'hffff);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, v0, dn0, {21'b0, ra0}, {16'b0, ins0}, {21'b0, ipc0});
    cmp(1, v1, dn1, {27'b0, ra1}, {16'b0, ins1}, {27'b0, ipc1});
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pc(input int pc);
    int budget;
    budget = 50;
    while (!(v0 === 1'b1 && int'(ipc0) == pc) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_pc: got no instr_pc 0x%0h within 50 cycles, expected it presented", pc);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int prev, last1;
    rst_n = 1'b0; ready = 1'b1; halt = 1'b0; jv = 1'b0; ja = '0;
    repeat (2) @(negedge clk);
    check("reset.instr_valid", {31'b0, v0}, 0);
    check("reset.instr", {16'b0, ins0}, 0);
    check("reset.instr_pc", {21'b0, ipc0}, 0);
    check("reset.done", {31'b0, dn0}, 0);
    check("reset.rom_addr", {21'b0, ra0}, 0);
    rst_n = 1'b1;

    // first issue of address 0, then word 0 two edges after release
    @(negedge clk);
    check("first.rom_addr", {21'b0, ra0}, 1);
    check("first.instr_valid", {31'b0, v0}, 0);
    @(negedge clk);
    check("lat2.instr_pc", {21'b0, ipc0}, 0);
    check("lat2.instr", {16'b0, ins0}, 32'h100);
    @(negedge clk);
    check("stream.instr_pc", {21'b0, ipc0}, 1);
    check("stream.instr", {16'b0, ins0}, 32'h101);

    // consumer stall at word 3
    wait_pc(3);
    ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall.instr_pc", {21'b0, ipc0}, 3);
      check("stall.instr", {16'b0, ins0}, 32'h103);
    end
    ready = 1'b1;
    @(negedge clk);
    check("resume.instr_pc", {21'b0, ipc0}, 4);
    @(negedge clk);
    check("resume2.instr_pc", {21'b0, ipc0}, 5);

    // jump to 40 while word 7 is presented
    wait_pc(7);
    jv = 1'b1; ja = 11'd40;
    @(negedge clk);
    jv = 1'b0; ja = '0;
    check("jump.valid_e1", {31'b0, v0}, 0);
    @(negedge clk);
    check("jump.valid_e2", {31'b0, v0}, 0);
    @(negedge clk);
    check("jump.instr_pc", {21'b0, ipc0}, 40);
    check("jump.instr", {16'b0, ins0}, 32'h128);

    // halt for 3 cycles mid-stream; accepted addresses must stay consecutive
    prev = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (v0 && ready) begin
        if (prev >= 0) check("halt.seq", {21'b0, ipc0}, prev + 1);
        prev = int'(ipc0);
      end
      halt = (k >= 2 && k < 5);
    end
    halt = 1'b0;

    // run the small ROM to its end
    jv = 1'b1; ja = 11'd2;
    @(negedge clk);
    jv = 1'b0; ja = '0;
    last1 = -1;
    repeat (30) begin
      @(negedge clk);
      if (v1 && ready) last1 = int'(ipc1);
    end
    check("end.last_pc", last1, 15);
    check("end.done", {31'b0, dn1}, 1);
    check("end.rom_addr", {27'b0, ra1}, 15);
    check("end.instr_valid", {31'b0, v1}, 0);
    jv = 1'b1; ja = 11'd2;
    @(negedge clk);
    jv = 1'b0; ja = '0;
    check("restart.done", {31'b0, dn1}, 0);
    repeat (2) @(negedge clk);
    check("restart.instr_valid", {31'b0, v1}, 1);
    check("restart.instr_pc", {27'b0, ipc1}, 2);

    // reset with two words buffered
    ready = 1'b0;
    repeat (4) @(negedge clk);
    check("prereset.instr_valid", {31'b0, v0}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.valid_big", {31'b0, v0}, 0);
    check("midreset.valid_small", {31'b0, v1}, 0);
    check("midreset.instr", {16'b0, ins0}, 0);
    check("midreset.instr_pc", {21'b0, ipc0}, 0);
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    repeat (2) @(negedge clk);
    check("postreset.instr_valid", {31'b0, v0}, 1);
    check("postreset.instr_pc", {21'b0, ipc0}, 0);

    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      rst_n = 1'b1;
      halt  = ($urandom_range(0, 4) == 0);
      ready = ($urandom_range(0, 9) < 7);
      jv    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) ja = 11'($urandom_range(0, 2047));
      else ja = 11'($urandom_range(1008, 1023));
      if ($urandom_range(0, 399) == 0) #2 rst_n = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1; halt = 1'b0; jv = 1'b0; ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
